// File: rtl/demo_seq_pkg.sv
// Shared types and constants for the demo scene sequencer: scene length table,
// sequencer state enum and the full-brightness level.
package demo_seq_pkg;

  localparam int SCENE_TBL_N = 4;
  localparam int SCENE_LEN [SCENE_TBL_N] = '{64, 128, 32, 256};

  localparam logic [3:0] FADE_MAX = 4'd15;

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    FADE_OUT = 2'd1,
    FADE_IN  = 2'd2
  } seq_state_e;

  // Scenes beyond the table reuse it cyclically so NUM_SCENES may exceed it.
  function automatic int scene_len(input int idx);
    return SCENE_LEN[idx % SCENE_TBL_N];
  endfunction

endpackage

// File: rtl/demo_seq_tick.sv
// Frame tick generator: merges frame_start with single-step edges while paused.
module demo_seq_tick (
  input  logic clk,
  input  logic reset,
  input  logic frame_start,
  input  logic pause,
  input  logic step,
  output logic tick
);

  logic step_q;

  always_ff @(posedge clk) begin
    if (reset) step_q <= 1'b0;
    else       step_q <= step;
  end

  // Exactly one source is selected per cycle, so coincident events give one tick.
  assign tick = pause ? (step & ~step_q) : frame_start;

endmodule

// File: rtl/demo_scene_sequencer.sv
// Frame-rate scene sequencer: scene index, scene-local frame count and fade level.
// Optional fade-out/fade-in between scenes is enabled by defining DEMO_SEQ_FADE_EN.
module demo_scene_sequencer
  import demo_seq_pkg::*;
#(
  parameter int NUM_SCENES = 4,
  parameter int FRAME_BITS = 10,
  parameter int FADE_STEP  = 2
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          frame_start,
  input  logic                          pause,
  input  logic                          step,
  input  logic                          manual,
  input  logic [$clog2(NUM_SCENES)-1:0] scene_sel,
  output logic [$clog2(NUM_SCENES)-1:0] scene,
  output logic [FRAME_BITS-1:0]         scene_frame,
  output logic [3:0]                    fade,
  output logic                          scene_change
);

  localparam int SCENE_W = $clog2(NUM_SCENES);

  if (FADE_STEP < 1 || FADE_STEP > 15) begin : g_bad_fade_step
    $error("FADE_STEP must lie in 1..15");
  end

`ifdef DEMO_SEQ_FADE_EN
  localparam seq_state_e RST_STATE = FADE_IN;
  localparam logic [3:0] RST_FADE  = 4'd0;
`else
  localparam seq_state_e RST_STATE = RUN;
  localparam logic [3:0] RST_FADE  = FADE_MAX;
`endif

  seq_state_e            state, state_nxt;
  logic                  tick;
  logic                  override, scene_end;
  logic [SCENE_W-1:0]    scene_nxt, scene_inc;
  logic [FRAME_BITS-1:0] frame_nxt, frame_inc;
  logic [3:0]            fade_nxt;
  logic                  change_nxt;

`ifdef DEMO_SEQ_FADE_EN
  logic [3:0] fade_dn, fade_up;

  function automatic logic [3:0] sat_sub(input logic [3:0] f);
    int signed t;
    t = int'(f) - FADE_STEP;
    if (t < 0) t = 0;
    return 4'(t);
  endfunction

  function automatic logic [3:0] sat_add(input logic [3:0] f);
    int signed t;
    t = int'(f) + FADE_STEP;
    if (t > int'(FADE_MAX)) t = int'(FADE_MAX);
    return 4'(t);
  endfunction

  assign fade_dn = sat_sub(fade);
  assign fade_up = sat_add(fade);
`endif

  function automatic logic [SCENE_W-1:0] next_scene(input logic [SCENE_W-1:0] s);
    int n;
    n = int'(s) + 1;
    if (n >= NUM_SCENES) n = 0;
    return SCENE_W'(n);
  endfunction

  demo_seq_tick u_tick (
    .clk         (clk),
    .reset       (reset),
    .frame_start (frame_start),
    .pause       (pause),
    .step        (step),
    .tick        (tick)
  );

  assign override  = manual && (int'(scene_sel) < NUM_SCENES) && (scene_sel != scene);
  assign scene_end = (int'(scene_frame) == scene_len(int'(scene)) - 1);
  assign scene_inc = next_scene(scene);
  assign frame_inc = scene_frame + FRAME_BITS'(1);

  always_ff @(posedge clk) begin
    if (reset) state <= RST_STATE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (tick) begin
      if (override) begin
        state_nxt = RUN;
      end else begin
`ifdef DEMO_SEQ_FADE_EN
        case (state)
          RUN:      if (scene_end)             state_nxt = FADE_OUT;
          FADE_OUT: if (fade_dn == 4'd0)       state_nxt = FADE_IN;
          FADE_IN:  if (fade_up == FADE_MAX)   state_nxt = RUN;
          default:                             state_nxt = RUN;
        endcase
`else
        state_nxt = RUN;
`endif
      end
    end
  end

  always_comb begin
    scene_nxt  = scene;
    frame_nxt  = scene_frame;
    fade_nxt   = fade;
    change_nxt = 1'b0;
    if (tick) begin
      if (override) begin
        scene_nxt  = scene_sel;
        frame_nxt  = '0;
        fade_nxt   = FADE_MAX;
        change_nxt = 1'b1;
      end else begin
        frame_nxt = frame_inc;
        case (state)
`ifdef DEMO_SEQ_FADE_EN
          FADE_OUT: begin
            fade_nxt = fade_dn;
            if (fade_dn == 4'd0) begin
              scene_nxt  = scene_inc;
              frame_nxt  = '0;
              change_nxt = 1'b1;
            end
          end
          FADE_IN: fade_nxt = fade_up;
          default: ;
`else
          default: begin
            // Without fades the scene switches on the very tick that ends it.
            if (scene_end) begin
              scene_nxt  = scene_inc;
              frame_nxt  = '0;
              change_nxt = 1'b1;
            end
          end
`endif
        endcase
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      scene        <= '0;
      scene_frame  <= '0;
      fade         <= RST_FADE;
      scene_change <= 1'b0;
    end else begin
      scene        <= scene_nxt;
      scene_frame  <= frame_nxt;
      fade         <= fade_nxt;
      scene_change <= change_nxt;
    end
  end

endmodule

// File: doc/demo_scene_sequencer.md
# demo_scene_sequencer

Frame-rate scheduler for the demo: counts frames, steps through a fixed table of scenes, and drives the scene index, the scene-local frame counter and a global brightness (fade) level into the pixel datapath. It sits between the raster timing generator (source of `frame_start`) and the effect/palette logic. It also handles the user controls: pause, single-step and manual scene select.

## Interface
- `NUM_SCENES`, default 4: number of scenes; scene index wraps at this value.
- `FRAME_BITS`, default 10: width of the scene-local frame counter.
- `FADE_STEP`, default 2: brightness change per frame during fades.
- `clk` in 1: the single clock.
- `reset` in 1: synchronous, active-high reset.
- `frame_start` in 1: one-cycle pulse at start of vertical blanking.
- `pause` in 1: level; freezes all frame-driven state.
- `step` in 1: level; each rising edge advances one frame while paused.
- `manual` in 1: level; enables manual scene select.
- `scene_sel` in $clog2(NUM_SCENES): requested scene when `manual`=1.
- `scene` out $clog2(NUM_SCENES): current scene index.
- `scene_frame` out FRAME_BITS: frames elapsed in current scene.
- `fade` out 4: brightness, 0 = black, 15 = full.
- `scene_change` out 1: one-cycle pulse when `scene` takes a new value.

## Operation
- Tick: an internal `tick` = (`frame_start` & !`pause`) | (`step` rising edge & `pause`). If both sources fire in one cycle, only one tick results. All state below changes only on tick, except reset.
- `step` edge detect uses a registered copy of `step`. Reset clears the copy to 0.
- States: RUN, FADE_OUT, FADE_IN.
- RUN, on tick:
  - `scene_frame` += 1, wrapping at 2^FRAME_BITS.
  - If `scene_frame` == SCENE_LEN[scene]-1 before the increment, go to FADE_OUT; `scene_frame` still increments.
- FADE_OUT, on tick:
  - `fade` -= FADE_STEP, saturating at 0; `scene_frame` += 1.
  - When the result is 0: `scene` ← (`scene`+1) mod NUM_SCENES, `scene_frame` ← 0, pulse `scene_change`, go to FADE_IN.
- FADE_IN, on tick:
  - `fade` += FADE_STEP, saturating at 15; `scene_frame` += 1.
  - When the result is 15, go to RUN.
- Manual override: on a tick with `manual`=1 and `scene_sel` ≠ `scene`:
  - `scene` ← `scene_sel`, `scene_frame` ← 0, `fade` ← 15, state ← RUN, pulse `scene_change`.
  - This takes priority over all state transitions.
  - `scene_sel` ≥ NUM_SCENES is ignored.
- Reset values:
  - `scene`=0, `scene_frame`=0, `scene_change`=0.
  - With the fade feature: `fade`=0, state FADE_IN, so the demo fades in from black.
  - Without the fade feature: `fade`=15, state RUN.
- Reset mid-fade or mid-scene returns to the reset values on the next cycle, with no `scene_change` pulse.

## Timing
- All outputs are registered; latency is 1 cycle from tick to the updated outputs.
- `scene_change` is high for exactly the cycle in which the new `scene` first appears.
- `pause` sampled high in the same cycle as `frame_start`: no tick.
- `frame_start` is a pulse; a level held high is counted once per cycle (not supported by the raster generator).

## Configuration
- `DEMO_SEQ_FADE_EN` defined: the FADE_OUT and FADE_IN states and the fade arithmetic are compiled in, as described above.
- Not defined:
  - No fade states, and `fade` is constant 15.
  - At the end of a scene, the same tick advances `scene`, clears `scene_frame` and pulses `scene_change`; the state stays RUN.

## Structure
- Package `demo_seq_pkg` holds:
  - `SCENE_LEN[NUM_SCENES]` frame-count table, default {64, 128, 32, 256}.
  - The state enum (RUN, FADE_OUT, FADE_IN).
  - `FADE_MAX` = 15.
- Sub-module `demo_seq_tick` holds the `step` edge detector and the pause/step/`frame_start` merge, and outputs `tick`.
- Everything else stays in `demo_scene_sequencer`.

## Test plan
- Reset, fade enabled, 8 `frame_start` pulses:
  - `fade` goes 0,2,…,14,15 and state becomes RUN; `scene`=0, `scene_frame`=8.
- 64 frames in RUN on scene 0, then 8 more:
  - FADE_OUT gives `fade` 13,11,…,1,0.
  - On the final tick `scene`=1, `scene_frame`=0, and `scene_change` is high for exactly 1 cycle.
- `pause`=1 with 20 `frame_start` pulses: no output changes. Then 3 `step` rising edges: `scene_frame` +3.
  - A `step` edge coincident with `frame_start` while paused gives +1 only.
- Mid-FADE_OUT, `manual`=1 with `scene_sel`=3, then a tick:
  - `scene`=3, `fade`=15, state RUN, `scene_frame`=0, one `scene_change` pulse.
  - `scene_sel` held at 3 afterwards produces no further pulses.
- Wrap, with DEMO_SEQ_FADE_EN undefined:
  - From scene 3, after 256 ticks `scene`=0, same cycle as `scene_change`; `fade` stays 15 throughout.
- Assert `reset` mid-FADE_IN with `fade`=6: next cycle all outputs equal the reset values, no `scene_change`.
